// File: rtl/level_pkg.sv
// -----------------------------------------------------------------------------
// level_pkg
// Shared definitions for the level sequencer and the bitmap mux.
//   state_t         : sequencer FSM states
//   LEVEL_*         : levelCode values that select the background bitmap
//   level_code_of() : maps an FSM state to the levelCode it displays
// -----------------------------------------------------------------------------
package level_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PLAY_L1,
        S_TRANS,
        S_PLAY_L2,
        S_WIN,
        S_LOST
    } state_t;

    localparam logic [1:0] LEVEL_ONE   = 2'b00;
    localparam logic [1:0] LEVEL_TWO   = 2'b01;
    localparam logic [1:0] LEVEL_TRANS = 2'b10;
    localparam logic [1:0] LEVEL_END   = 2'b11;

    function automatic logic [1:0] level_code_of(input state_t s);
        logic [1:0] code;
        case (s)
            S_TRANS:      code = LEVEL_TRANS;
            S_PLAY_L2:    code = LEVEL_TWO;
            S_WIN,
            S_LOST:       code = LEVEL_END;
            default:      code = LEVEL_ONE;   // IDLE and PLAY_L1
        endcase
        return code;
    endfunction

endpackage

// File: rtl/frame_timer.sv
// -----------------------------------------------------------------------------
// frame_timer
// Counts startOfFrame pulses up to a terminal count and flags the pulse that
// reaches it. The count saturates at the terminal value and never wraps.
// Ports:
//   clk               : system clock
//   resetN            : asynchronous active-low reset (count -> 0)
//   clear_i           : synchronous clear, dominates counting
//   startOfFrame_i    : one-cycle pulse per video frame
//   terminalCount_i   : count value at which done_o fires
//   done_o            : high in the cycle whose frame pulse reaches terminal
// -----------------------------------------------------------------------------
module frame_timer #(
    parameter int unsigned WIDTH = 7
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             clear_i,
    input  logic             startOfFrame_i,
    input  logic [WIDTH-1:0] terminalCount_i,
    output logic             done_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             at_terminal;

    assign at_terminal = (count_q == terminalCount_i);

    always_comb begin
        // NOTE: assign every always_comb output a default first so no path leaves it unassigned (latch).
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (startOfFrame_i && !at_terminal) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    // count_q + 1 cannot overflow here because count_q < terminalCount_i.
    assign done_o = !clear_i && startOfFrame_i && !at_terminal &&
                    ((count_q + WIDTH'(1)) == terminalCount_i);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            count_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking (<=) so all flops update together at the edge.
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/level_sequencer.sv
// -----------------------------------------------------------------------------
// level_sequencer
// Game flow controller: IDLE -> PLAY_L1 -> TRANS -> PLAY_L2 -> WIN, with LOST
// reachable from either play level once the last life is used.
// Inputs are level signals; each is edge detected so a held key counts once.
// The detected edges are registered, and the FSM plus all outputs are
// registered one clock later.
// Ports:
//   clk, resetN       : clock, asynchronous active-low reset
//   startOfFrame      : one-cycle pulse per video frame (counted in TRANS)
//   startKey          : start / restart key (level)
//   levelComplete     : goal reached (level)
//   playerDied        : hazard hit (level)
//   skipKey           : acts as levelComplete in play (LEVEL_SKIP_EN only)
//   levelCode         : bitmap select (see level_pkg LEVEL_* constants)
//   livesLeft         : remaining lives
//   levelLoadReq      : one-cycle pulse requesting object re-initialisation
//   transitionActive  : high in TRANS
//   gameWon, gameOver : high in WIN / LOST
// Build option: define LEVEL_SKIP_EN to add the skipKey input.
// -----------------------------------------------------------------------------
module level_sequencer
    import level_pkg::*;
#(
    parameter int unsigned TRANSITION_FRAMES = 120,
    parameter int unsigned INIT_LIVES        = 3
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       startOfFrame,
    input  logic       startKey,
    input  logic       levelComplete,
    input  logic       playerDied,
`ifdef LEVEL_SKIP_EN
    input  logic       skipKey,
`endif
    output logic [1:0] levelCode,
    output logic [1:0] livesLeft,
    output logic       levelLoadReq,
    output logic       transitionActive,
    output logic       gameWon,
    output logic       gameOver
);

    localparam int unsigned     CNT_W      = $clog2(TRANSITION_FRAMES + 1);
    localparam logic [CNT_W-1:0] TERM_CNT  = CNT_W'(TRANSITION_FRAMES);
    localparam logic [1:0]      LIVES_INIT = 2'(INIT_LIVES);

    // Edge detection. Bit order: 0 start, 1 complete, 2 died, 3 skip.
`ifdef LEVEL_SKIP_EN
    localparam int unsigned NUM_IN = 4;
    logic [NUM_IN-1:0] raw_in;
    assign raw_in = {skipKey, playerDied, levelComplete, startKey};
`else
    localparam int unsigned NUM_IN = 3;
    logic [NUM_IN-1:0] raw_in;
    assign raw_in = {playerDied, levelComplete, startKey};
`endif

    logic [NUM_IN-1:0] hist_q;
    logic [NUM_IN-1:0] ev_q;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            hist_q <= '0;
            ev_q   <= '0;
        end else begin
            hist_q <= raw_in;
            ev_q   <= raw_in & ~hist_q;
        end
    end

    logic start_ev;
    logic complete_ev;
    logic died_ev;

    assign start_ev = ev_q[0];
    assign died_ev  = ev_q[2];
`ifdef LEVEL_SKIP_EN
    // complete_ev is only acted on in the play states, so OR-ing skip in here
    // gives skip exactly the levelComplete behaviour.
    assign complete_ev = ev_q[1] | ev_q[3];
`else
    assign complete_ev = ev_q[1];
`endif

    // FSM and registered outputs.
    state_t     state_q, state_d;
    logic [1:0] lives_q, lives_d;
    logic       load_q,  load_d;
    logic [1:0] code_q,  code_d;
    logic       trans_q, trans_d;
    logic       won_q,   won_d;
    logic       over_q,  over_d;
    logic       frame_done;

    // The counter is held clear outside TRANS, so it always starts from zero
    // when the level-one goal is reached.
    frame_timer #(
        .WIDTH (CNT_W)
    ) u_frame_timer (
        .clk             (clk),
        .resetN          (resetN),
        .clear_i         (state_q != S_TRANS),
        .startOfFrame_i  (startOfFrame),
        .terminalCount_i (TERM_CNT),
        .done_o          (frame_done)
    );

    // State register (also holds the registered outputs).
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= S_IDLE;
            lives_q <= LIVES_INIT;
            load_q  <= 1'b0;
            code_q  <= LEVEL_ONE;
            trans_q <= 1'b0;
            won_q   <= 1'b0;
            over_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lives_q <= lives_d;
            load_q  <= load_d;
            code_q  <= code_d;
            trans_q <= trans_d;
            won_q   <= won_d;
            over_q  <= over_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        lives_d = lives_q;
        load_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_ev) begin
                    state_d = S_PLAY_L1;
                    load_d  = 1'b1;
                end
            end
            S_PLAY_L1, S_PLAY_L2: begin
                // Goal beats death when both arrive together; lives untouched.
                if (complete_ev) begin
                    state_d = (state_q == S_PLAY_L1) ? S_TRANS : S_WIN;
                end else if (died_ev) begin
                    if (lives_q > 2'd1) begin
                        lives_d = lives_q - 2'd1;
                        load_d  = 1'b1;
                    end else begin
                        lives_d = 2'd0;
                        state_d = S_LOST;
                    end
                end
            end
            S_TRANS: begin
                if (frame_done) begin
                    state_d = S_PLAY_L2;
                    load_d  = 1'b1;
                end
            end
            S_WIN, S_LOST: begin
                if (start_ev) begin
                    state_d = S_IDLE;
                    lives_d = LIVES_INIT;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output logic, computed from the next state so outputs and state
    // register on the same edge.
    always_comb begin
        code_d  = level_code_of(state_d);
        trans_d = (state_d == S_TRANS);
        won_d   = (state_d == S_WIN);
        over_d  = (state_d == S_LOST);
    end

    assign levelCode        = code_q;
    assign livesLeft        = lives_q;
    assign levelLoadReq     = load_q;
    assign transitionActive = trans_q;
    assign gameWon          = won_q;
    assign gameOver         = over_q;

endmodule

// File: tb/tb_level_sequencer.sv
// -----------------------------------------------------------------------------
// tb_level_sequencer
// Scoreboard bench for level_sequencer with TRANSITION_FRAMES = 4 and
// INIT_LIVES = 3. Expected output snapshots are queued before each stimulus
// and compared once the DUT has had time to respond. levelLoadReq pulses are
// counted by a monitor and compared as a delta per step.
// Define LEVEL_SKIP_EN to include the skipKey scenario.
// -----------------------------------------------------------------------------
module tb_level_sequencer;
    import level_pkg::*;

    localparam int TF = 4;

    logic       clk = 1'b0;
    logic       resetN;
    logic       startOfFrame;
    logic       startKey;
    logic       levelComplete;
    logic       playerDied;
`ifdef LEVEL_SKIP_EN
    logic       skipKey;
`endif
    logic [1:0] levelCode;
    logic [1:0] livesLeft;
    logic       levelLoadReq;
    logic       transitionActive;
    logic       gameWon;
    logic       gameOver;

    always #5 clk = ~clk;

    level_sequencer #(
        .TRANSITION_FRAMES (TF),
        .INIT_LIVES        (3)
    ) dut (
        .clk              (clk),
        .resetN           (resetN),
        .startOfFrame     (startOfFrame),
        .startKey         (startKey),
        .levelComplete    (levelComplete),
        .playerDied       (playerDied),
`ifdef LEVEL_SKIP_EN
        .skipKey          (skipKey),
`endif
        .levelCode        (levelCode),
        .livesLeft        (livesLeft),
        .levelLoadReq     (levelLoadReq),
        .transitionActive (transitionActive),
        .gameWon          (gameWon),
        .gameOver         (gameOver)
    );

    int n_compared = 0;
    int n_mismatch = 0;
    int load_total = 0;

    // Pulse monitor: the request is a full-cycle flop output, so it is seen
    // exactly once per pulse on the falling edge.
    always @(negedge clk) begin
        if (levelLoadReq === 1'b1) load_total++;
    end

    task automatic check(input string tag, input int actual, input int expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatch++;
            $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    typedef struct {
        string tag;
        int    code;
        int    lives;
        int    trans;
        int    won;
        int    over;
        int    loads;
        int    base;
    } exp_t;

    exp_t sb_q[$];

    task automatic expect_out(input string tag, input int code, input int lives,
                              input int trans, input int won, input int over,
                              input int loads);
        exp_t e;
        e.tag = tag; e.code = code; e.lives = lives; e.trans = trans;
        e.won = won; e.over = over; e.loads = loads; e.base = load_total;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check({e.tag, ".code"},  int'(levelCode),        e.code);
            check({e.tag, ".lives"}, int'(livesLeft),        e.lives);
            check({e.tag, ".trans"}, int'(transitionActive), e.trans);
            check({e.tag, ".won"},   int'(gameWon),          e.won);
            check({e.tag, ".over"},  int'(gameOver),         e.over);
            check({e.tag, ".loads"}, load_total - e.base,    e.loads);
        end
    endtask

    // Input mask bits: 1 start, 2 complete, 4 died, 8 frame, 16 skip.
    task automatic drive(input int mask, input int hold);
        @(negedge clk);
        startKey      = mask[0];
        levelComplete = mask[1];
        playerDied    = mask[2];
        startOfFrame  = mask[3];
`ifdef LEVEL_SKIP_EN
        skipKey       = mask[4];
`endif
        repeat (hold) @(negedge clk);
        startKey = 1'b0; levelComplete = 1'b0; playerDied = 1'b0; startOfFrame = 1'b0;
`ifdef LEVEL_SKIP_EN
        skipKey  = 1'b0;
`endif
        repeat (3) @(negedge clk);
    endtask

    // Walk from IDLE to PLAY_L2 with full lives, checking along the way.
    task automatic reach_l2(input string tag);
        expect_out({tag, "_l1"}, LEVEL_ONE, 3, 0, 0, 0, 1);
        drive(1, 2); drain();
        expect_out({tag, "_trans"}, LEVEL_TRANS, 3, 1, 0, 0, 0);
        drive(2, 2); drain();
        for (int i = 1; i <= TF; i++) begin
            if (i < TF) expect_out($sformatf("%s_f%0d", tag, i), LEVEL_TRANS, 3, 1, 0, 0, 0);
            else        expect_out($sformatf("%s_f%0d", tag, i), LEVEL_TWO,   3, 0, 0, 0, 1);
            drive(8, 1); drain();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        resetN = 1'b0;
        startKey = 1'b0; levelComplete = 1'b0; playerDied = 1'b0; startOfFrame = 1'b0;
`ifdef LEVEL_SKIP_EN
        skipKey = 1'b0;
`endif
        repeat (3) @(negedge clk);
        expect_out("reset", LEVEL_ONE, 3, 0, 0, 0, 0);
        drain();
        resetN = 1'b1;
        repeat (2) @(negedge clk);

        // Test 1: start held for 10 cycles gives exactly one load pulse.
        expect_out("t1_start_held", LEVEL_ONE, 3, 0, 0, 0, 1);
        drive(1, 10); drain();
        // Start ignored in PLAY_L1.
        expect_out("t1_start_ignored", LEVEL_ONE, 3, 0, 0, 0, 0);
        drive(1, 2); drain();

        // Test 2: goal, death ignored in TRANS, then exactly TF frames.
        expect_out("t2_trans", LEVEL_TRANS, 3, 1, 0, 0, 0);
        drive(2, 3); drain();
        expect_out("t2_died_ignored", LEVEL_TRANS, 3, 1, 0, 0, 0);
        drive(4 | 2 | 1, 2); drain();
        for (int i = 1; i <= TF; i++) begin
            if (i < TF) expect_out($sformatf("t2_frame%0d", i), LEVEL_TRANS, 3, 1, 0, 0, 0);
            else        expect_out($sformatf("t2_frame%0d", i), LEVEL_TWO,   3, 0, 0, 0, 1);
            drive(8, 1); drain();
        end

        // Test 3: three deaths in PLAY_L2.
        expect_out("t3_start_ignored", LEVEL_TWO, 3, 0, 0, 0, 0);
        drive(1, 2); drain();
        expect_out("t3_die1", LEVEL_TWO, 2, 0, 0, 0, 1);
        drive(4, 4); drain();
        expect_out("t3_die2", LEVEL_TWO, 1, 0, 0, 0, 1);
        drive(4, 1); drain();
        expect_out("t3_die3", LEVEL_END, 0, 0, 0, 1, 0);
        drive(4, 2); drain();
        expect_out("t3_restart", LEVEL_ONE, 3, 0, 0, 0, 0);
        drive(1, 2); drain();

        // Test 4: goal and death together in PLAY_L1.
        expect_out("t4_start", LEVEL_ONE, 3, 0, 0, 0, 1);
        drive(1, 2); drain();
        expect_out("t4_both", LEVEL_TRANS, 3, 1, 0, 0, 0);
        drive(2 | 4, 2); drain();

        // Test 5: reset mid-transition after 2 frames.
        expect_out("t5_two_frames", LEVEL_TRANS, 3, 1, 0, 0, 0);
        drive(8, 1); drive(8, 1); drain();
        expect_out("t5_async", LEVEL_ONE, 3, 0, 0, 0, 0);
        @(negedge clk);
        #2 resetN = 1'b0;
        #1 drain();
        expect_out("t5_held", LEVEL_ONE, 3, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        drain();
        resetN = 1'b1;
        repeat (2) @(negedge clk);

        // Death in PLAY_L1 keeps the level, lives carry into level two, win.
        expect_out("l1_start", LEVEL_ONE, 3, 0, 0, 0, 1);
        drive(1, 2); drain();
        expect_out("l1_die", LEVEL_ONE, 2, 0, 0, 0, 1);
        drive(4, 2); drain();
        expect_out("l1_goal", LEVEL_TRANS, 2, 1, 0, 0, 0);
        drive(2, 2); drain();
        for (int i = 1; i <= TF; i++) drive(8, 1);
        expect_out("l2_goal_win", LEVEL_END, 2, 0, 1, 0, 0);
        drive(2, 2); drain();
        expect_out("win_restart", LEVEL_ONE, 3, 0, 0, 0, 0);
        drive(1, 2); drain();

`ifdef LEVEL_SKIP_EN
        // Test 6: skip in PLAY_L2 wins.
        reach_l2("t6");
        expect_out("t6_skip_win", LEVEL_END, 3, 0, 1, 0, 0);
        drive(16, 2); drain();
`else
        reach_l2("t6_noskip");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule
